// File: rtl/acc_mac_responder_if.sv
// Offload channel between the accelerator interconnect and a responder.
// q-channel carries requests in, p-channel carries in-order responses out.
interface acc_mac_responder_if #(
   parameter int unsigned DataWidth = 32
) ();

   logic                 q_valid;
   logic [DataWidth-1:0] q_addr;
   logic [31:0]          q_data_op;
   logic [DataWidth-1:0] q_data_arga;
   logic [DataWidth-1:0] q_data_argb;
   logic [DataWidth-1:0] q_data_argc;
   logic [4:0]           q_id;
   logic                 q_ready;

   logic                 p_valid;
   logic [DataWidth-1:0] p_data;
   logic [4:0]           p_id;
   logic                 p_error;
   logic                 p_ready;

   modport master (
      output q_valid, q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, p_ready,
      input  q_ready, p_valid, p_data, p_id, p_error
   );

   modport slave (
      input  q_valid, q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, p_ready,
      output q_ready, p_valid, p_data, p_id, p_error
   );

endinterface

// File: rtl/acc_mac_responder.sv
// Integer MUL/MULH/MULHU/MAC responder with a fixed-depth, globally stalled pipeline.
// The full result is computed at acceptance and then carried through Latency stages.
module acc_mac_responder #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Latency   = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   acc_mac_responder_if.slave  acc_io,
   output logic                busy_o
);

   localparam logic [2:0] OpMul   = 3'b000;
   localparam logic [2:0] OpMulh  = 3'b001;
   localparam logic [2:0] OpMulhu = 3'b010;
   localparam logic [2:0] OpMac   = 3'b011;

   logic [Latency-1:0]   vld_q;
   logic [DataWidth-1:0] data_q [Latency];
   logic [4:0]           id_q   [Latency];
   logic [Latency-1:0]   err_q;

   logic                   stall;
   logic                   accept;
   logic [2:0]             funct3;
   logic [2*DataWidth-1:0] prod_u;
   logic [2*DataWidth-1:0] prod_s;
   logic [DataWidth-1:0]   res_data_d;
   logic                   res_err_d;
   logic                   unused_req;

   assign stall  = vld_q[Latency-1] && !acc_io.p_ready;
   assign accept = acc_io.q_valid && !stall;
   assign funct3 = acc_io.q_data_op[14:12];

   // Signed product via sign-extended operands: the low 2*DataWidth bits match a signed multiply.
   assign prod_u = {{DataWidth{1'b0}}, acc_io.q_data_arga} *
                   {{DataWidth{1'b0}}, acc_io.q_data_argb};
   assign prod_s = {{DataWidth{acc_io.q_data_arga[DataWidth-1]}}, acc_io.q_data_arga} *
                   {{DataWidth{acc_io.q_data_argb[DataWidth-1]}}, acc_io.q_data_argb};

   assign unused_req = ^{acc_io.q_addr, acc_io.q_data_op[31:15], acc_io.q_data_op[11:0],
                         prod_s[DataWidth-1:0]};

   always_comb begin
      res_data_d = '0;
      res_err_d  = 1'b0;
      case (funct3)
         OpMul:   res_data_d = prod_u[DataWidth-1:0];
         OpMulh:  res_data_d = prod_s[2*DataWidth-1:DataWidth];
         OpMulhu: res_data_d = prod_u[2*DataWidth-1:DataWidth];
         OpMac:   res_data_d = prod_u[DataWidth-1:0] + acc_io.q_data_argc;
         default: res_err_d  = 1'b1;
      endcase
   end

   // Bubbles are inserted as zeroed invalid entries so an idle output never shows stale data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < Latency; i++) begin
            data_q[i] <= '0;
            id_q[i]   <= '0;
         end
      end else if (!stall) begin
         vld_q[0]  <= accept;
         data_q[0] <= accept ? res_data_d : '0;
         id_q[0]   <= accept ? acc_io.q_id : 5'd0;
         err_q[0]  <= accept && res_err_d;
         for (int i = 1; i < Latency; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
            id_q[i]   <= id_q[i-1];
            err_q[i]  <= err_q[i-1];
         end
      end
   end

   assign acc_io.q_ready = !stall;
   assign acc_io.p_valid = vld_q[Latency-1];
   assign acc_io.p_data  = data_q[Latency-1];
   assign acc_io.p_id    = id_q[Latency-1];
   assign acc_io.p_error = err_q[Latency-1];
   assign busy_o         = |vld_q;

endmodule

// File: tb/tb_acc_mac_responder.sv
// Directed bench for acc_mac_responder: latency, op results, backpressure, illegal op, reset.
module tb_acc_mac_responder;

   localparam int unsigned DW  = 32;
   localparam int unsigned Lat = 3;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;
   logic busy;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   acc_mac_responder_if #(.DataWidth(DW)) bus ();

   acc_mac_responder #(
      .DataWidth (DW),
      .Latency   (Lat)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .acc_io (bus),
      .busy_o (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [4:0] id);
      bus.q_valid     = 1'b1;
      bus.q_addr      = 32'hdead_0000;
      bus.q_data_op   = {17'd0, f3, 12'd0};
      bus.q_data_arga = a;
      bus.q_data_argb = b;
      bus.q_data_argc = c;
      bus.q_id        = id;
   endtask

   task automatic idle();
      bus.q_valid = 1'b0;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] data, input logic [4:0] id,
                          input logic err);
      chk({tag, ".valid"}, bus.p_valid, 1'b1);
      chk({tag, ".data"},  bus.p_data,  data);
      chk({tag, ".id"},    bus.p_id,    id);
      chk({tag, ".error"}, bus.p_error, err);
   endtask

   initial begin
      bus.q_valid     = 1'b0;
      bus.q_addr      = '0;
      bus.q_data_op   = '0;
      bus.q_data_arga = '0;
      bus.q_data_argb = '0;
      bus.q_data_argc = '0;
      bus.q_id        = '0;
      bus.p_ready     = 1'b1;

      // Reset state
      #3;
      chk("rst.p_valid", bus.p_valid, 1'b0);
      chk("rst.p_data",  bus.p_data,  32'd0);
      chk("rst.p_id",    bus.p_id,    5'd0);
      chk("rst.p_error", bus.p_error, 1'b0);
      chk("rst.busy",    busy,        1'b0);
      chk("rst.q_ready", bus.q_ready, 1'b1);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // MUL 7*6, id 5: valid exactly three cycles after the handshake cycle
      send(3'b000, 32'd7, 32'd6, 32'd0, 5'd5);
      tick();
      idle();
      chk("mul.lat1", bus.p_valid, 1'b0);
      chk("mul.busy", busy, 1'b1);
      tick();
      chk("mul.lat2", bus.p_valid, 1'b0);
      tick();
      chk_rsp("mul", 32'd42, 5'd5, 1'b0);
      tick();
      chk("mul.retired", bus.p_valid, 1'b0);

      // MULH then MULHU back-to-back
      send(3'b001, 32'h8000_0000, 32'd2, 32'd0, 5'd1);
      tick();
      send(3'b010, 32'h8000_0000, 32'd2, 32'd0, 5'd2);
      tick();
      idle();
      tick();
      chk_rsp("mulh", 32'hffff_ffff, 5'd1, 1'b0);
      tick();
      chk_rsp("mulhu", 32'h0000_0001, 5'd2, 1'b0);
      tick();

      // MAC with wrap: 0xffffffff*2 + 3
      send(3'b011, 32'hffff_ffff, 32'd2, 32'd3, 5'd7);
      tick();
      idle();
      tick();
      tick();
      chk_rsp("mac", 32'h0000_0001, 5'd7, 1'b0);
      tick();

      // Backpressure: ids 1..4, MUL k*k; stall five cycles from first p_valid
      for (int k = 1; k <= 3; k++) begin
         send(3'b000, k, k, 32'd0, 5'(k));
         tick();
      end
      send(3'b000, 32'd4, 32'd4, 32'd0, 5'd4);
      bus.p_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp.q_ready", bus.q_ready, 1'b0);
         chk("bp.p_valid", bus.p_valid, 1'b1);
         chk("bp.p_id",    bus.p_id,    5'd1);
         chk("bp.p_data",  bus.p_data,  32'd1);
         tick();
      end
      bus.p_ready = 1'b1;
      #1;
      chk("bp.release_q_ready", bus.q_ready, 1'b1);
      chk_rsp("bp1", 32'd1, 5'd1, 1'b0);
      tick();
      idle();
      chk_rsp("bp2", 32'd4, 5'd2, 1'b0);
      tick();
      chk_rsp("bp3", 32'd9, 5'd3, 1'b0);
      tick();
      chk_rsp("bp4", 32'd16, 5'd4, 1'b0);
      tick();
      chk("bp.drained", bus.p_valid, 1'b0);

      // Illegal funct3 followed by a legal MUL
      send(3'b111, 32'd12, 32'd13, 32'd14, 5'd9);
      tick();
      send(3'b000, 32'd3, 32'd5, 32'd0, 5'd10);
      tick();
      idle();
      tick();
      chk_rsp("ill", 32'd0, 5'd9, 1'b1);
      tick();
      chk_rsp("ill.next", 32'd15, 5'd10, 1'b0);
      tick();

      // Async reset with two requests in flight, the first already at the output
      send(3'b000, 32'd2, 32'd2, 32'd0, 5'd11);
      tick();
      send(3'b000, 32'd3, 32'd3, 32'd0, 5'd12);
      tick();
      idle();
      tick();
      chk("ar.pre_valid", bus.p_valid, 1'b1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("ar.p_valid", bus.p_valid, 1'b0);
      chk("ar.busy",    busy,        1'b0);
      chk("ar.q_ready", bus.q_ready, 1'b1);
      chk("ar.p_data",  bus.p_data,  32'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("ar.no_stale", bus.p_valid, 1'b0);
      end
      chk("ar.post_q_ready", bus.q_ready, 1'b1);
      chk("ar.post_busy",    busy,        1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
